vga_frame_sink: RTL and testbench
=================================

# vga_frame_sink

Receiving end of the SoC pixel stream. The block accepts the 8-bit grayscale stream that the mode-1 and mode-2 pipelines emit (`pixel`/`pixel_en`) and writes it in raster order into an external simple-dual-port frame BRAM. It also runs an 800x600@72 Hz VGA timing generator that reads the frame BRAM back and drives RGB444 and the sync outputs. It sits between the SoC pixel mux and the board VGA connector.

## Interface
Parameters:
- `IMG_W`, 540, image width in pixels
- `IMG_H`, 540, image height in pixels
- `CLK_DIV`, 2, system clocks per VGA pixel; legal values are ≥2 (50 MHz pixel rate from a 100 MHz clk)
- `H_ACT`/`H_FP`/`H_SYNC`/`H_BP`, 800/56/120/64, horizontal timing in pixels
- `V_ACT`/`V_FP`/`V_SYNC`/`V_BP`, 600/37/6/23, vertical timing in lines

Ports:
- `clk` in 1: system clock, single clock domain.
- `rst_n` in 1: reset, asynchronous, active-low.
- `pixel_i` in 8: stream pixel.
- `pixel_en_i` in 1: stream pixel valid, one pixel per high cycle.
- `frame_clr_i` in 1: restarts the write pointer at (0,0).
- `wr_done_o` out 1: one-cycle pulse when the last pixel of a frame is written.
- `frame_valid_o` out 1: sticky; at least one complete frame is stored.
- `fb_we_o` out 1, `fb_waddr_o` out 19, `fb_wdata_o` out 8: BRAM write port.
- `fb_raddr_o` out 19: BRAM read address.
- `fb_rdata_i` in 8: BRAM read data; read latency is 1 clk.
- `vga_r_o`, `vga_g_o`, `vga_b_o` out 4 each: colour outputs.
- `hsync_o`, `vsync_o` out 1: sync outputs, active-high.

## Operation
Write side:
- `wptr` counts 0..IMG_W·IMG_H−1.
- When `pixel_en_i` is high, the block issues one write: `fb_we_o`=1, `fb_waddr_o`=`wptr`, `fb_wdata_o`=`pixel_i`, all registered. `wptr` then increments.
- At `wptr`=IMG_W·IMG_H−1 (291599), `wptr` wraps to 0. `wr_done_o` pulses in the same cycle as that write's `fb_we_o`, and `frame_valid_o` is set.
- `frame_clr_i` takes priority over `pixel_en_i`: `wptr` goes to 0, the coincident pixel is dropped (no write), and `frame_valid_o` is unchanged.
- With no `pixel_en_i`, `fb_we_o`=0; address and data hold their last value.

Read side:
- A divider asserts `pix_ce` for one clk every CLK_DIV clocks. It is free-running from reset.
- `h_cnt` runs 0..H_TOT−1 (1039) and `v_cnt` runs 0..V_TOT−1 (665). Both advance only on `pix_ce`; `v_cnt` advances when `h_cnt` wraps.
- `row_base` is incremental, with no multiplier: cleared when `v_cnt` wraps, and increased by IMG_W at each `h_cnt` wrap while `v_cnt`<IMG_H.
- In-image condition: `h_cnt`<IMG_W and `v_cnt`<IMG_H. When it holds, `fb_raddr_o`=`row_base`+`h_cnt`, registered one clk after the counter update.
- Video output:
  - In-image and `frame_valid_o`=1: R=G=B=`fb_rdata_i[7:4]`.
  - Otherwise: R=G=B=0.
- `hsync_o`=1 for `h_cnt` in [H_ACT+H_FP, H_ACT+H_FP+H_SYNC−1] = [856, 975].
- `vsync_o`=1 for `v_cnt` in [637, 642].

Reset:
- All outputs are 0.
- `wptr`, `h_cnt`, `v_cnt`, `row_base` and the divider are 0.
- A reset mid-frame abandons the partial frame and clears `frame_valid_o`.

## Timing
- Write latency: `pixel_en_i` at edge t produces `fb_we_o` at t+1.
- Read pipeline:
  - Counters update on the `pix_ce` edge t.
  - `fb_raddr_o` is valid at t+1.
  - `fb_rdata_i` is sampled at t+2.
  - RGB and both syncs are registered on the next `pix_ce` edge (≥t+2).
- All video outputs therefore lag the counters by exactly one pixel period. Syncs are delayed identically, so the RGB/sync alignment is exact.
- Write and read sides are independent. The same address may be written and read in one cycle; read-during-write returns old data, and this is acceptable (tearing is tolerated).
- The stream may be bursty or continuous at up to 1 pixel/clk; the block never stalls it.

## Test plan
- **Reset:** hold `rst_n`=0 mid-activity. All outputs read 0; after release, the first `hsync_o` rise occurs exactly 856·CLK_DIV+CLK_DIV clocks later.
- **Full frame:** drive 291600 continuous pixels with `pixel_i`=addr[7:0]. Each `fb_waddr_o` equals its index; `wr_done_o` pulses once with `fb_waddr_o`=291599; `frame_valid_o` rises; the next pixel writes address 0.
- **Clear collision:** after 1000 pixels, assert `frame_clr_i` together with `pixel_en_i`. No write occurs that cycle; the next pixel writes address 0.
- **Sync timing:** count over two frames. `hsync_o` high for 120 pixels per 1040-pixel line; `vsync_o` high for 6 lines per 666-line frame; 50 MHz·CLK_DIV check of 72.1 Hz.
- **Readback:** BRAM model preloaded with 0xA5 at (row 10, col 20) and `frame_valid_o`=1. At `v_cnt`=10, `h_cnt`=20, `fb_raddr_o`=5420, and RGB=0xA one pixel later. Pixels at col ≥540 or row ≥540 output 0.
- **Invalid frame:** before any complete frame, RGB=0 everywhere while syncs run normally.

Source files
------------

// File: rtl/vga_frame_sink.sv
// vga_frame_sink: writes an 8-bit grayscale pixel stream in raster order into an
// external frame BRAM and scans it back out as RGB444 VGA with active-high syncs.
// Ports:
//   clk, rst_n                     system clock, async active-low reset
//   pixel_i, pixel_en_i            incoming pixel stream (one pixel per enabled cycle)
//   frame_clr_i                    restart the write pointer at (0,0), drops a coincident pixel
//   wr_done_o, frame_valid_o       last-pixel-of-frame pulse, sticky "a frame is stored"
//   fb_we_o, fb_waddr_o, fb_wdata_o  BRAM write port
//   fb_raddr_o, fb_rdata_i         BRAM read port (1 clk read latency)
//   vga_r_o, vga_g_o, vga_b_o      colour outputs
//   hsync_o, vsync_o               sync outputs
module vga_frame_sink #(
    parameter int IMG_W   = 540,
    parameter int IMG_H   = 540,
    parameter int CLK_DIV = 2,
    parameter int H_ACT   = 800,
    parameter int H_FP    = 56,
    parameter int H_SYNC  = 120,
    parameter int H_BP    = 64,
    parameter int V_ACT   = 600,
    parameter int V_FP    = 37,
    parameter int V_SYNC  = 6,
    parameter int V_BP    = 23
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  pixel_i,
    input  logic        pixel_en_i,
    input  logic        frame_clr_i,
    output logic        wr_done_o,
    output logic        frame_valid_o,
    output logic        fb_we_o,
    output logic [18:0] fb_waddr_o,
    output logic [7:0]  fb_wdata_o,
    output logic [18:0] fb_raddr_o,
    input  logic [7:0]  fb_rdata_i,
    output logic [3:0]  vga_r_o,
    output logic [3:0]  vga_g_o,
    output logic [3:0]  vga_b_o,
    output logic        hsync_o,
    output logic        vsync_o
);
    localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
    localparam logic [15:0] H_LAST   = 16'(H_TOT - 1);
    localparam logic [15:0] V_LAST   = 16'(V_TOT - 1);
    localparam logic [15:0] HS_BEG   = 16'(H_ACT + H_FP);
    localparam logic [15:0] HS_END   = 16'(H_ACT + H_FP + H_SYNC - 1);
    localparam logic [15:0] VS_BEG   = 16'(V_ACT + V_FP);
    localparam logic [15:0] VS_END   = 16'(V_ACT + V_FP + V_SYNC - 1);
    localparam logic [15:0] IW       = 16'(IMG_W);
    localparam logic [15:0] IH       = 16'(IMG_H);
    localparam logic [18:0] ROW_STEP = 19'(IMG_W);
    localparam logic [18:0] W_LAST   = 19'(IMG_W * IMG_H - 1);
    localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);

    logic [18:0] r_wptr, r_waddr, r_raddr, r_rb;
    logic [7:0]  r_wdata, r_div;
    logic        r_we, r_done, r_fvalid, r_hs, r_vs;
    logic [15:0] r_h, r_v;
    logic [3:0]  r_pix;

    logic        w_wlast, w_ce, w_hwrap, w_vwrap, w_in_img, w_in_nxt;
    logic [15:0] w_h_nxt, w_v_nxt;
    logic [18:0] w_rb_nxt;

    assign w_wlast = (r_wptr == W_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr   <= '0;
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_we     <= 1'b0;
            r_done   <= 1'b0;
            r_fvalid <= 1'b0;
        end else if (frame_clr_i) begin
            r_wptr <= '0;
            r_we   <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_we   <= pixel_en_i;
            r_done <= pixel_en_i && w_wlast;
            if (pixel_en_i) begin
                r_waddr <= r_wptr;
                r_wdata <= pixel_i;
                r_wptr  <= w_wlast ? '0 : r_wptr + 19'd1;
                if (w_wlast) r_fvalid <= 1'b1;
            end
        end
    end

    // Next-state of the scan counters is computed here so the read address can be
    // registered on the same pix_ce edge as the counters; the BRAM then has a full
    // clock to return data before the next pix_ce edge registers the video outputs.
    always_comb begin
        w_ce     = (r_div == DIV_LAST);
        w_hwrap  = (r_h == H_LAST);
        w_vwrap  = (r_v == V_LAST);
        w_h_nxt  = w_hwrap ? '0 : r_h + 16'd1;
        w_v_nxt  = !w_hwrap ? r_v : w_vwrap ? '0 : r_v + 16'd1;
        w_rb_nxt = !w_hwrap ? r_rb : w_vwrap ? '0 : (r_v < IH) ? r_rb + ROW_STEP : r_rb;
        w_in_img = (r_h < IW) && (r_v < IH);
        w_in_nxt = (w_h_nxt < IW) && (w_v_nxt < IH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div   <= '0;
            r_h     <= '0;
            r_v     <= '0;
            r_rb    <= '0;
            r_raddr <= '0;
            r_pix   <= '0;
            r_hs    <= 1'b0;
            r_vs    <= 1'b0;
        end else begin
            r_div <= w_ce ? '0 : r_div + 8'd1;
            if (w_ce) begin
                r_h  <= w_h_nxt;
                r_v  <= w_v_nxt;
                r_rb <= w_rb_nxt;
                if (w_in_nxt) r_raddr <= w_rb_nxt + 19'(w_h_nxt);
                // Outputs describe the pixel the counters held until this edge,
                // giving RGB and syncs the same one-pixel lag.
                r_pix <= (w_in_img && r_fvalid) ? 4'(fb_rdata_i >> 4) : 4'd0;
                r_hs  <= (r_h >= HS_BEG) && (r_h <= HS_END);
                r_vs  <= (r_v >= VS_BEG) && (r_v <= VS_END);
            end
        end
    end

    assign fb_we_o       = r_we;
    assign fb_waddr_o    = r_waddr;
    assign fb_wdata_o    = r_wdata;
    assign wr_done_o     = r_done;
    assign frame_valid_o = r_fvalid;
    assign fb_raddr_o    = r_raddr;
    assign vga_r_o       = r_pix;
    assign vga_g_o       = r_pix;
    assign vga_b_o       = r_pix;
    assign hsync_o       = r_hs;
    assign vsync_o       = r_vs;
endmodule

// File: tb/tb_vga_frame_sink.sv
// tb_vga_frame_sink: directed + randomized self-checking bench for vga_frame_sink
// using a reduced image/timing geometry and a behavioural BRAM.
module tb_vga_frame_sink;
    localparam int IW = 6, IH = 4, CDIV = 2;
    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 6, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int NPIX = IW * IH;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [7:0]  pixel_i = 8'd0;
    logic        pixel_en_i = 1'b0, frame_clr_i = 1'b0;
    logic [7:0]  fb_rdata_i;
    logic        wr_done_o, frame_valid_o, fb_we_o, hsync_o, vsync_o;
    logic [18:0] fb_waddr_o, fb_raddr_o;
    logic [7:0]  fb_wdata_o;
    logic [3:0]  vga_r_o, vga_g_o, vga_b_o;

    logic [7:0]  bram    [0:31];
    logic [7:0]  exp_mem [0:31];
    int          n_tests = 0, n_fail = 0, cyc, ptr, n_done;
    logic [18:0] exp_addr;
    logic [7:0]  exp_data;
    logic        exp_fv;

    vga_frame_sink #(
        .IMG_W(IW), .IMG_H(IH), .CLK_DIV(CDIV),
        .H_ACT(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACT(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pixel_i(pixel_i), .pixel_en_i(pixel_en_i),
        .frame_clr_i(frame_clr_i), .wr_done_o(wr_done_o), .frame_valid_o(frame_valid_o),
        .fb_we_o(fb_we_o), .fb_waddr_o(fb_waddr_o), .fb_wdata_o(fb_wdata_o),
        .fb_raddr_o(fb_raddr_o), .fb_rdata_i(fb_rdata_i),
        .vga_r_o(vga_r_o), .vga_g_o(vga_g_o), .vga_b_o(vga_b_o),
        .hsync_o(hsync_o), .vsync_o(vsync_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else cyc <= cyc + 1;

    always @(posedge clk) begin
        if (fb_we_o) bram[fb_waddr_o[4:0]] <= fb_wdata_o;
        fb_rdata_i <= bram[fb_raddr_o[4:0]];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {1'b0, wr_done_o, frame_valid_o, fb_we_o, fb_waddr_o, fb_wdata_o,
                fb_raddr_o, vga_r_o, vga_g_o, vga_b_o, hsync_o, vsync_o};
    endfunction

    // One stream cycle: drive, advance the write model, check the registered result.
    task automatic step(input logic en, input logic clr, input logic [7:0] pix);
        logic exp_we, exp_done;
        @(negedge clk);
        pixel_en_i = en; frame_clr_i = clr; pixel_i = pix;
        exp_we = en && !clr;
        exp_done = 1'b0;
        if (clr) ptr = 0;
        else if (en) begin
            exp_addr = 19'(ptr);
            exp_data = pix;
            exp_mem[ptr] = pix;
            exp_done = (ptr == NPIX - 1);
            if (exp_done) exp_fv = 1'b1;
            ptr = exp_done ? 0 : ptr + 1;
        end
        @(posedge clk); #1;
        chk("we", 64'(fb_we_o), 64'(exp_we));
        chk("waddr", 64'(fb_waddr_o), 64'(exp_addr));
        chk("wdata", 64'(fb_wdata_o), 64'(exp_data));
        chk("wr_done", 64'(wr_done_o), 64'(exp_done));
        chk("frame_valid", 64'(frame_valid_o), 64'(exp_fv));
        if (wr_done_o) n_done++;
    endtask

    // Video model: after n clocks since reset, n/CDIV pixel ticks have occurred;
    // the read address follows the current scan position, the outputs the previous one.
    task automatic vid(input logic fv);
        int k, s, h, v, hk, vk;
        logic [3:0] er;
        logic eh, ev;
        @(negedge clk);
        k = cyc / CDIV;
        hk = k % HT;
        vk = (k / HT) % VT;
        if (hk < IW && vk < IH) chk("raddr", 64'(fb_raddr_o), 64'(vk * IW + hk));
        er = 4'd0; eh = 1'b0; ev = 1'b0;
        if (k > 0) begin
            s = k - 1;
            h = s % HT;
            v = (s / HT) % VT;
            eh = (h >= HA + HF) && (h < HA + HF + HS);
            ev = (v >= VA + VF) && (v < VA + VF + VS);
            if (fv && h < IW && v < IH) er = exp_mem[v * IW + h][7:4];
        end
        chk("rgb", 64'({vga_r_o, vga_g_o, vga_b_o}), 64'({er, er, er}));
        chk("hsync", 64'(hsync_o), 64'(eh));
        chk("vsync", 64'(vsync_o), 64'(ev));
    endtask

    initial begin
        int first_rise, hs_hi, vs_hi, hs_rises;
        logic prev_hs;
        for (int i = 0; i < 32; i++) begin
            bram[i] = 8'($urandom);
            exp_mem[i] = 8'd0;
        end
        pixel_en_i = 1'b1; pixel_i = 8'h55;
        repeat (4) @(posedge clk);
        #1 chk("reset_outputs", all_outs(), 64'd0);
        @(negedge clk);
        pixel_en_i = 1'b0;
        rst_n = 1'b1;
        ptr = 0; exp_addr = '0; exp_data = '0; exp_fv = 1'b0;

        first_rise = -1; hs_hi = 0; vs_hi = 0; hs_rises = 0; prev_hs = 1'b0;
        for (int i = 0; i < 2 * HT * VT * CDIV; i++) begin
            vid(1'b0);
            if (hsync_o) hs_hi++;
            if (vsync_o) vs_hi++;
            if (hsync_o && !prev_hs) begin
                hs_rises++;
                if (first_rise < 0) first_rise = cyc;
            end
            prev_hs = hsync_o;
        end
        chk("first_hsync_rise", 64'(first_rise), 64'((HA + HF) * CDIV + CDIV));
        chk("hsync_high_clks", 64'(hs_hi), 64'(2 * VT * HS * CDIV));
        chk("vsync_high_clks", 64'(vs_hi), 64'(2 * VS * HT * CDIV));
        chk("hsync_lines", 64'(hs_rises), 64'(2 * VT));

        n_done = 0;
        for (int i = 0; i < NPIX; i++) step(1'b1, 1'b0, 8'(i));
        chk("done_count", 64'(n_done), 64'd1);
        step(1'b1, 1'b0, 8'hEE);

        repeat (9) step(1'b1, 1'b0, 8'($urandom));
        step(1'b1, 1'b1, 8'h77);
        step(1'b1, 1'b0, 8'h12);

        repeat (200) step($urandom_range(0, 2) != 0, $urandom_range(0, 30) == 0, 8'($urandom));

        step(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < NPIX; i++) step(1'b1, 1'b0, (i == 2 * IW + 3) ? 8'hA5 : 8'($urandom));
        repeat (20) step(1'b0, 1'b0, 8'h00);

        repeat (HT * VT * CDIV) vid(exp_fv);

        repeat (5) step(1'b1, 1'b0, 8'($urandom));
        @(negedge clk);
        pixel_en_i = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("midframe_reset_outputs", all_outs(), 64'd0);
        @(negedge clk);
        pixel_en_i = 1'b0;
        rst_n = 1'b1;
        ptr = 0; exp_addr = '0; exp_data = '0; exp_fv = 1'b0;
        step(1'b1, 1'b0, 8'h3C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
